// File: rtl/lcd_bus_driver.sv
// HD44780-class LCD write-cycle generator: setup/enable/hold timing, 8- or 4-bit bus, execution wait.
// Define LCD_BUSY_POLL_EN to replace the fixed execution wait with busy-flag read polling.
module lcd_bus_driver #(
    parameter int unsigned BUS_WIDTH   = 8,
    parameter int unsigned T_AS        = 2,
    parameter int unsigned T_PW        = 12,
    parameter int unsigned T_H         = 2,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 82000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
`ifdef LCD_BUSY_POLL_EN
    ,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_DATA_OE,
    output logic       oErr
`endif
);

    // Counter reload values are phase length minus one; zero-length phases stretch to one cycle.
    localparam logic [CNT_W-1:0] AS_LD  = CNT_W'((T_AS == 0) ? 0 : T_AS - 1);
    localparam logic [CNT_W-1:0] PW_LD  = CNT_W'((T_PW == 0) ? 0 : T_PW - 1);
    localparam logic [CNT_W-1:0] H_LD   = CNT_W'((T_H == 0) ? 0 : T_H - 1);
    localparam logic [CNT_W-1:0] EXL_LD = CNT_W'((T_EXEC_LONG == 0) ? 0 : T_EXEC_LONG - 1);
    localparam bit               NIBBLE = (BUS_WIDTH == 4);

    typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StExec} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       lo_nib_q;
    logic             nib2_q;

`ifdef LCD_BUSY_POLL_EN
    logic             rd_q;
    logic             bf_q;
    logic [CNT_W-1:0] tmo_q;
    logic             unused_din;
    assign unused_din = ^LCD_DATA_IN[6:0];
`else
    localparam logic [CNT_W-1:0] EX_LD = CNT_W'((T_EXEC == 0) ? 0 : T_EXEC - 1);
    logic             long_q;
    assign LCD_RW = 1'b0;
`endif

    assign oReady = (state_q == StIdle);
    assign oBusy  = !oReady;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            lo_nib_q <= '0;
            nib2_q   <= 1'b0;
            oDone    <= 1'b0;
            LCD_EN   <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
`ifdef LCD_BUSY_POLL_EN
            rd_q        <= 1'b0;
            bf_q        <= 1'b0;
            tmo_q       <= '0;
            LCD_RW      <= 1'b0;
            LCD_DATA_OE <= 1'b1;
            oErr        <= 1'b0;
`else
            long_q   <= 1'b0;
`endif
        end else begin
            oDone <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            oErr <= 1'b0;
            if (rd_q && tmo_q != '0) tmo_q <= tmo_q - 1'b1;
            // Poll window exhausted: give up on the busy flag and release the bus.
            if (rd_q && tmo_q == '0) begin
                state_q     <= StIdle;
                rd_q        <= 1'b0;
                nib2_q      <= 1'b0;
                LCD_EN      <= 1'b0;
                LCD_RW      <= 1'b0;
                LCD_DATA_OE <= 1'b1;
                oDone       <= 1'b1;
                oErr        <= 1'b1;
            end else
`endif
            begin
                case (state_q)
                    StIdle: begin
                        if (iValid) begin
                            LCD_RS   <= iRS;
                            LCD_DATA <= NIBBLE ? {iDATA[7:4], 4'h0} : iDATA;
                            lo_nib_q <= iDATA[3:0];
                            nib2_q   <= 1'b0;
                            cnt_q    <= AS_LD;
                            state_q  <= StSetup;
`ifndef LCD_BUSY_POLL_EN
                            long_q   <= !iRS && (iDATA == 8'h01 || iDATA == 8'h02 ||
                                                 iDATA == 8'h03);
`endif
                        end
                    end
                    StSetup: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            LCD_EN  <= 1'b1;
                            cnt_q   <= PW_LD;
                            state_q <= StPulse;
                        end
                    end
                    StPulse: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
`ifdef LCD_BUSY_POLL_EN
                            // In nibble mode only the first read of a pair carries the flag.
                            if (rd_q && (!NIBBLE || !nib2_q)) bf_q <= LCD_DATA_IN[7];
`endif
                            LCD_EN  <= 1'b0;
                            cnt_q   <= H_LD;
                            state_q <= StHold;
                        end
                    end
                    StHold: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (NIBBLE && !nib2_q) begin
                            nib2_q   <= 1'b1;
                            LCD_DATA <= {lo_nib_q, 4'h0};
                            cnt_q    <= AS_LD;
                            state_q  <= StSetup;
                        end else begin
`ifdef LCD_BUSY_POLL_EN
                            nib2_q <= 1'b0;
                            if (!rd_q) begin
                                rd_q        <= 1'b1;
                                LCD_RW      <= 1'b1;
                                LCD_RS      <= 1'b0;
                                LCD_DATA_OE <= 1'b0;
                                tmo_q       <= EXL_LD;
                                cnt_q       <= AS_LD;
                                state_q     <= StSetup;
                            end else if (bf_q) begin
                                cnt_q   <= AS_LD;
                                state_q <= StSetup;
                            end else begin
                                rd_q        <= 1'b0;
                                LCD_RW      <= 1'b0;
                                LCD_DATA_OE <= 1'b1;
                                oDone       <= 1'b1;
                                state_q     <= StIdle;
                            end
`else
                            cnt_q   <= long_q ? EXL_LD : EX_LD;
                            state_q <= StExec;
`endif
                        end
                    end
`ifndef LCD_BUSY_POLL_EN
                    StExec: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            oDone   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
`endif
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver: one 8-bit and one 4-bit instance, directed transfers.
// Expectations are queued at accept time; a negedge monitor pops and compares on each oDone.
module tb_lcd_bus_driver;

    localparam int unsigned T_AS        = 2;
    localparam int unsigned T_PW        = 4;
    localparam int unsigned T_H         = 2;
    localparam int unsigned T_EXEC      = 10;
    localparam int unsigned T_EXEC_LONG = 40;

    typedef struct {
        int         inst;
        int         done_cyc;
        int         en1;
        logic [7:0] d1;
        int         en2;
        logic [7:0] d2;
        logic       rs;
        int         busy;
        int         nrd;
        logic       err;
    } exp_t;

    logic       iCLK   = 1'b0;
    logic       iRST_N = 1'b0;
    logic [7:0] data   = 8'h00;
    logic       rs     = 1'b0;
    logic       valid [2];
    logic       ready [2];
    logic       done  [2];
    logic       busy_o[2];
    logic       rw    [2];
    logic       en    [2];
    logic       lrs   [2];
    logic [7:0] ldata [2];
`ifdef LCD_BUSY_POLL_EN
    logic [7:0] din[2];
    logic       oe [2];
    logic       err[2];
`endif

    exp_t       sbq[$];
    exp_t       e;
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         nrise[2], nread[2], busycnt[2], en_start[2];
    int         rise_cyc[2][2];
    logic [7:0] rise_dat[2][2];
    logic       rise_rs[2];
    logic       en_prev[2];
    logic       bf_stuck = 1'b0;

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

`ifdef LCD_BUSY_POLL_EN
    // Busy flag: high for the first three reads of a poll, or permanently when stuck.
    assign din[0] = {(bf_stuck || nread[0] < 4), 7'd0};
    assign din[1] = 8'h00;
`endif

    lcd_bus_driver #(
        .BUS_WIDTH(8), .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H),
        .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG), .CNT_W(20)
    ) dut8 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(data), .iRS(rs), .iValid(valid[0]),
        .oReady(ready[0]), .oDone(done[0]), .oBusy(busy_o[0]),
        .LCD_DATA(ldata[0]), .LCD_RW(rw[0]), .LCD_EN(en[0]), .LCD_RS(lrs[0])
`ifdef LCD_BUSY_POLL_EN
        , .LCD_DATA_IN(din[0]), .LCD_DATA_OE(oe[0]), .oErr(err[0])
`endif
    );

    lcd_bus_driver #(
        .BUS_WIDTH(4), .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H),
        .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG), .CNT_W(20)
    ) dut4 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(data), .iRS(rs), .iValid(valid[1]),
        .oReady(ready[1]), .oDone(done[1]), .oBusy(busy_o[1]),
        .LCD_DATA(ldata[1]), .LCD_RW(rw[1]), .LCD_EN(en[1]), .LCD_RS(lrs[1])
`ifdef LCD_BUSY_POLL_EN
        , .LCD_DATA_IN(din[1]), .LCD_DATA_OE(oe[1]), .oErr(err[1])
`endif
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic push(input int inst, input int base, input int done_rel, input int en1_rel,
                        input logic [7:0] d1, input int en2_rel, input logic [7:0] d2,
                        input logic r, input int busy, input int nrd, input logic er);
        exp_t x;
        x.inst = inst; x.done_cyc = base + done_rel; x.en1 = base + en1_rel; x.d1 = d1;
        x.en2 = (en2_rel < 0) ? -1 : base + en2_rel; x.d2 = d2; x.rs = r;
        x.busy = busy; x.nrd = nrd; x.err = er;
        sbq.push_back(x);
    endtask

    // Returns the cyc value of the accepting cycle (relative cycle 0); ends in relative cycle 1.
    task automatic send(input int i, input logic [7:0] d, input logic r, output int base);
        int n;
        @(negedge iCLK);
        data = d; rs = r; valid[i] = 1'b1;
        n = 0;
        while (!ready[i] && n < 300) begin
            @(negedge iCLK);
            n++;
        end
        if (!ready[i]) check("accept_timeout", 0, 1);
        base = cyc;
        @(negedge iCLK);
        valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge iCLK);
            n++;
        end
        check("scoreboard_drained", sbq.size(), 0);
        repeat (3) @(negedge iCLK);
    endtask

    initial forever begin
        @(negedge iCLK);
        for (int i = 0; i < 2; i++) begin
            if (!iRST_N) begin
                nrise[i] = 0; nread[i] = 0; busycnt[i] = 0; en_prev[i] = 1'b0;
            end else begin
                if (en[i] && !en_prev[i]) begin
                    en_start[i] = cyc;
                    if (rw[i]) begin
                        nread[i]++;
`ifdef LCD_BUSY_POLL_EN
                        check("read_oe", oe[i], 0);
                        check("read_rs", lrs[i], 0);
`endif
                    end else begin
                        if (nrise[i] < 2) begin
                            rise_cyc[i][nrise[i]] = cyc;
                            rise_dat[i][nrise[i]] = ldata[i];
                        end
                        if (nrise[i] == 0) rise_rs[i] = lrs[i];
                        nrise[i]++;
                    end
                end
                if (!en[i] && en_prev[i]) check("en_width", cyc - en_start[i], T_PW);
                if (!ready[i]) busycnt[i]++;
                if (done[i]) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("done_inst", i, e.inst);
                        check("done_cycle", cyc, e.done_cyc);
                        check("write_strobes", nrise[i], (e.en2 < 0) ? 1 : 2);
                        check("en1_cycle", rise_cyc[i][0], e.en1);
                        check("en1_data", rise_dat[i][0], e.d1);
                        if (e.en2 >= 0) begin
                            check("en2_cycle", rise_cyc[i][1], e.en2);
                            check("en2_data", rise_dat[i][1], e.d2);
                        end
                        check("rs_value", rise_rs[i], e.rs);
                        check("busy_cycles", busycnt[i], e.busy);
                        check("obusy_at_done", busy_o[i], 0);
                        check("read_strobes", nread[i], e.nrd);
`ifdef LCD_BUSY_POLL_EN
                        check("err_at_done", err[i], e.err);
`endif
                    end
                    nrise[i] = 0; nread[i] = 0; busycnt[i] = 0;
                end
                en_prev[i] = en[i];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int b;
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        repeat (3) @(negedge iCLK);
        check("rst_en", en[0], 0);
        check("rst_rw", rw[0], 0);
        check("rst_rs", lrs[0], 0);
        check("rst_data", ldata[0], 8'h00);
        check("rst_ready", ready[0], 1);
        check("rst_done", done[0], 0);
        check("rst_busy", busy_o[0], 0);
`ifdef LCD_BUSY_POLL_EN
        check("rst_oe", oe[0], 1);
        check("rst_err", err[0], 0);
`endif
        #1 iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);

`ifndef LCD_BUSY_POLL_EN
        // 8-bit data write
        send(0, 8'h41, 1'b1, b);
        check("t1_data_cycle1", ldata[0], 8'h41);
        check("t1_rs_cycle1", lrs[0], 1);
        push(0, b, 19, 3, 8'h41, -1, 8'h00, 1'b1, 18, 0, 1'b0);
        drain();

        // 4-bit command write: two nibbles on [7:4]
        send(1, 8'h28, 1'b0, b);
        check("t2_data_cycle1", ldata[1], 8'h20);
        push(1, b, 27, 3, 8'h20, 11, 8'h80, 1'b0, 26, 0, 1'b0);
        drain();

        // clear display takes the long wait; same byte as data does not
        send(0, 8'h01, 1'b0, b);
        push(0, b, 49, 3, 8'h01, -1, 8'h00, 1'b0, 48, 0, 1'b0);
        drain();
        send(0, 8'h01, 1'b1, b);
        push(0, b, 19, 3, 8'h01, -1, 8'h00, 1'b1, 18, 0, 1'b0);
        drain();

        // back-to-back with iValid held high
        @(negedge iCLK);
        data = 8'h48; rs = 1'b1; valid[0] = 1'b1;
        b = cyc;
        check("t5_ready_first", ready[0], 1);
        push(0, b, 19, 3, 8'h48, -1, 8'h00, 1'b1, 18, 0, 1'b0);
        push(0, b, 38, 22, 8'h49, -1, 8'h00, 1'b1, 18, 0, 1'b0);
        @(negedge iCLK);
        data = 8'h49;
        for (int n = 0; n < 100 && !ready[0]; n++) @(negedge iCLK);
        check("t5_second_accept_cycle", cyc - b, 19);
        @(negedge iCLK);
        valid[0] = 1'b0;
        check("t5_second_data", ldata[0], 8'h49);
        drain();

        // async reset while LCD_EN is high
        send(0, 8'h55, 1'b1, b);
        repeat (3) @(negedge iCLK);
        check("t6_en_before_reset", en[0], 1);
        #1 iRST_N = 1'b0;
        #1 check("t6_en_async_drop", en[0], 0);
        @(negedge iCLK);
        #1 iRST_N = 1'b1;
        check("t6_ready_after_reset", ready[0], 1);
        repeat (60) @(negedge iCLK);
        check("t6_ready_idle", ready[0], 1);
`else
        // busy flag reads 1,1,1,0: four read strobes, then done
        bf_stuck = 1'b0;
        send(0, 8'h41, 1'b1, b);
        push(0, b, 41, 3, 8'h41, -1, 8'h00, 1'b1, 40, 4, 1'b0);
        drain();
        check("p1_rw_idle", rw[0], 0);
        check("p1_oe_idle", oe[0], 1);

        // busy flag stuck: timeout 40 cycles after poll entry
        bf_stuck = 1'b1;
        send(0, 8'h42, 1'b1, b);
        push(0, b, 49, 3, 8'h42, -1, 8'h00, 1'b1, 48, 5, 1'b1);
        drain();
        bf_stuck = 1'b0;
        check("p2_err_cleared", err[0], 0);
        check("p2_oe_idle", oe[0], 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
